matrix_scan_ctrl: RTL

//   Parametrised successor to the fixed 16x16 mux scan controller for the pressure-sensor array.

---
 rtl/matrix_scan_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_ctrl.sv
// Row/column mux scan controller: settles each point, averages 2^AVG_LOG2 ADC samples, streams one value per point.
// Optional FRAME_HEADER_EN macro prepends a two-beat 0xAA/0x55 header to every frame.
module matrix_scan_ctrl #(
  parameter  int ROWS       = 16,
  parameter  int COLS       = 16,
  parameter  int DATA_W     = 8,
  parameter  int SETTLE_CYC = 8,
  parameter  int AD_LAT     = 1,
  parameter  int AVG_LOG2   = 2,
  localparam int ROW_W      = $clog2(ROWS),
  localparam int COL_W      = $clog2(COLS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              continuous,
  output logic [ROW_W-1:0]  row_sel,
  output logic [COL_W-1:0]  col_sel,
  output logic              ad_clk,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       otr_cnt
);

  localparam int N_SMP   = 1 << AVG_LOG2;
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int SMP_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CNT_MAX = (SETTLE_CYC > AD_LAT) ? SETTLE_CYC : AD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_RC, S_SETTLE, S_SAMPLE, S_EMIT, S_DONE
`ifdef FRAME_HEADER_EN
    , S_HDR
`endif
  } state_t;

`ifdef FRAME_HEADER_EN
  localparam state_t FIRST_ST = S_HDR;
`else
  localparam state_t FIRST_ST = S_SET_RC;
`endif

  state_t              r_state, w_next;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [CNT_W-1:0]    r_cnt;
  logic [SMP_W-1:0]    r_smp;
  logic [ACC_W-1:0]    r_acc;
  logic                r_otr;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_frame_start;
  logic [15:0]         r_frame_cnt;
  logic [15:0]         r_otr_cnt;
`ifdef FRAME_HEADER_EN
  logic                r_hdr_idx;
`endif

  logic [ACC_W-1:0]    w_acc_next;
  logic                w_otr_next;
  logic                w_settle_last, w_cap, w_last_smp, w_last_pt, w_frame_go;

  assign w_acc_next    = r_acc + ACC_W'(ad_data);
  assign w_otr_next    = r_otr | ad_otr;
  assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_cap         = (r_cnt == CNT_W'(AD_LAT));
  assign w_last_smp    = (r_smp == SMP_W'(N_SMP - 1));
  assign w_last_pt     = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));
  assign w_frame_go    = ((r_state == S_IDLE) && start) || ((r_state == S_DONE) && continuous);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = FIRST_ST;
      S_SET_RC: w_next = S_SETTLE;
      S_SETTLE: if (w_settle_last) w_next = S_SAMPLE;
      S_SAMPLE: if (w_cap && w_last_smp) w_next = S_EMIT;
      S_EMIT:   if (m_ready) w_next = w_last_pt ? S_DONE : S_SET_RC;
      S_DONE:   w_next = continuous ? FIRST_ST : S_IDLE;
`ifdef FRAME_HEADER_EN
      S_HDR:    if (m_ready && r_hdr_idx) w_next = S_SET_RC;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ad_clk     = 1'b0;
    ad_oe      = 1'b0;
    m_valid    = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      S_IDLE:   begin busy = 1'b0; ad_oe = 1'b1; end
      S_SAMPLE: ad_clk = (r_cnt == '0);
      S_EMIT:   m_valid = 1'b1;
      S_DONE:   frame_done = 1'b1;
`ifdef FRAME_HEADER_EN
      S_HDR:    m_valid = 1'b1;
`endif
      default:  ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_row         <= '0;
      r_col         <= '0;
      r_cnt         <= '0;
      r_smp         <= '0;
      r_acc         <= '0;
      r_otr         <= 1'b0;
      r_m_data      <= '0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_otr_cnt     <= '0;
`ifdef FRAME_HEADER_EN
      r_hdr_idx     <= 1'b0;
`endif
    end else begin
      r_frame_start <= w_frame_go;
      if (w_frame_go) begin
        r_row <= '0;
        r_col <= '0;
`ifdef FRAME_HEADER_EN
        r_hdr_idx <= 1'b0;
        r_m_data  <= DATA_W'(8'hAA);
`endif
      end
      unique case (r_state)
        S_SET_RC: begin
          r_acc <= '0;
          r_otr <= 1'b0;
          r_cnt <= '0;
          r_smp <= '0;
        end
        S_SETTLE: r_cnt <= w_settle_last ? '0 : r_cnt + 1'b1;
        S_SAMPLE: begin
          if (w_cap) begin
            r_acc <= w_acc_next;
            r_otr <= w_otr_next;
            r_cnt <= '0;
            r_smp <= r_smp + 1'b1;
            // Over-range anywhere in the point forces full scale instead of the average.
            if (w_last_smp) begin
              r_m_data <= w_otr_next ? {DATA_W{1'b1}} : w_acc_next[AVG_LOG2 +: DATA_W];
              if (w_otr_next && (r_otr_cnt != 16'hFFFF)) r_otr_cnt <= r_otr_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (m_ready && !w_last_pt) begin
            if (r_col == COL_W'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DONE: r_frame_cnt <= r_frame_cnt + 1'b1;
`ifdef FRAME_HEADER_EN
        S_HDR: begin
          if (m_ready && !r_hdr_idx) begin
            r_hdr_idx <= 1'b1;
            r_m_data  <= DATA_W'(8'h55);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign row_sel     = r_row;
  assign col_sel     = r_col;
  assign m_data      = r_m_data;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign otr_cnt     = r_otr_cnt;

endmodule
